// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with multi-beat accumulator, bias injection and saturating output.
// Input register + L_TREE tree stages + accumulate + output gives L_TREE+2 cycles of latency.
module adder_tree_acc #(
  parameter int BITSIZE    = 14,
  parameter int NUM_INPUTS = 27,
  parameter int ACC_BITS   = 4,
  parameter int OUT_W      = 21,
  localparam int L_TREE    = $clog2(NUM_INPUTS),
  localparam int TREE_W    = BITSIZE + L_TREE,
  localparam int ACC_W     = TREE_W + ACC_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_adder,
  input  logic [NUM_INPUTS*BITSIZE-1:0] input_numbers,
  input  logic                          acc_first,
  input  logic                          acc_last,
  input  logic [ACC_W-1:0]              bias,
  output logic [OUT_W-1:0]              sum_output,
  output logic                          data_valid,
  output logic                          sat_flag
);

  function automatic int cnt_at(int k);
    int c = NUM_INPUTS;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  function automatic int off_at(int k);
    int o = 0;
    for (int i = 0; i < k; i++) o += cnt_at(i);
    return o;
  endfunction

  localparam int TOT     = off_at(L_TREE + 1);
  localparam int SUM_IDX = off_at(L_TREE);

  // All tree levels live in one flat array; level k occupies [off_at(k) +: cnt_at(k)].
  // Every node is carried at full TREE_W, so sign extension per level is implicit and exact.
  logic signed [TREE_W-1:0] tree [TOT];

  for (genvar j = 0; j < NUM_INPUTS; j++) begin : g_in
    always_ff @(posedge clk)
      if (!rst) tree[j] <= '0;
      else      tree[j] <= TREE_W'($signed(input_numbers[j*BITSIZE +: BITSIZE]));
  end

  for (genvar k = 1; k <= L_TREE; k++) begin : g_lvl
    for (genvar j = 0; j < cnt_at(k); j++) begin : g_node
      localparam int SRC = off_at(k-1) + 2*j;
      localparam int DST = off_at(k) + j;
      if (2*j + 1 < cnt_at(k-1)) begin : g_add
        always_ff @(posedge clk)
          if (!rst) tree[DST] <= '0;
          else      tree[DST] <= tree[SRC] + tree[SRC+1];
      end else begin : g_pass
        always_ff @(posedge clk)
          if (!rst) tree[DST] <= '0;
          else      tree[DST] <= tree[SRC];
      end
    end
  end

  logic [L_TREE:0]            vld_pipe, first_pipe, last_pipe;
  logic [L_TREE:0][ACC_W-1:0] bias_pipe;

  always_ff @(posedge clk)
    if (!rst) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      bias_pipe  <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[L_TREE-1:0], start_adder};
      first_pipe <= {first_pipe[L_TREE-1:0], acc_first};
      last_pipe  <= {last_pipe[L_TREE-1:0], acc_last};
      bias_pipe  <= {bias_pipe[L_TREE-1:0], bias};
    end

  logic signed [TREE_W-1:0] tree_sum;
  logic signed [ACC_W-1:0]  tree_ext, acc;
  logic                     acc_vld;

  assign tree_sum = tree[SUM_IDX];
  assign tree_ext = ACC_W'(tree_sum);

  always_ff @(posedge clk)
    if (!rst) begin
      acc     <= '0;
      acc_vld <= 1'b0;
    end else begin
      acc_vld <= vld_pipe[L_TREE] & last_pipe[L_TREE];
      if (vld_pipe[L_TREE])
        acc <= first_pipe[L_TREE] ? tree_ext + $signed(bias_pipe[L_TREE]) : acc + tree_ext;
    end

  logic [OUT_W-1:0] clamp_val;
  logic             clamp_hit;

  if (OUT_W < ACC_W) begin : g_clamp
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    always_comb begin
      clamp_hit = 1'b0;
      clamp_val = acc[OUT_W-1:0];
      if (acc > SAT_MAX) begin
        clamp_hit = 1'b1;
        clamp_val = SAT_MAX[OUT_W-1:0];
      end else if (acc < SAT_MIN) begin
        clamp_hit = 1'b1;
        clamp_val = SAT_MIN[OUT_W-1:0];
      end
    end
  end else begin : g_noclamp
    always_comb begin
      clamp_hit = 1'b0;
      clamp_val = OUT_W'(acc);
    end
  end

  always_ff @(posedge clk)
    if (!rst) begin
      sum_output <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      data_valid <= acc_vld;
      sat_flag   <= acc_vld & clamp_hit;
      if (acc_vld) sum_output <= clamp_val;
    end

endmodule

// File: doc/adder_tree_acc.md
Name: adder_tree_acc

Overview:
- Parametrised, fully pipelined signed adder tree that reduces NUM_INPUTS operands of BITSIZE bits into one sum.
- Adds a multi-pass accumulator with bias injection and output saturation, so a convolution window can be split across several input-channel beats.
- Sits between the MAC/multiplier array and the requantisation/activation stage of the MobileNetV3 conv datapath.
- Accepts one new operand vector per cycle; output rate is one result per completed accumulation group.

Parameters:
- BITSIZE, 14, width of each signed operand (fixed-point Q7.7 in the datapath).
- NUM_INPUTS, 27, number of operands per beat (any value >= 2).
- ACC_BITS, 4, guard bits added above the tree width for multi-beat accumulation.
- OUT_W, 21, width of the saturated output.
- Derived: L_TREE = $clog2(NUM_INPUTS); TREE_W = BITSIZE + L_TREE; ACC_W = TREE_W + ACC_BITS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- start_adder  input  1  beat valid; input_numbers/flags/bias are sampled when high.
- input_numbers  input  NUM_INPUTS*BITSIZE  packed signed operands; operand i at [i*BITSIZE +: BITSIZE].
- acc_first  input  1  beat opens a new accumulation group.
- acc_last  input  1  beat closes the group; result is emitted.
- bias  input  ACC_W  signed bias, sampled only on a beat with acc_first=1.
- sum_output  output  OUT_W  signed saturated group result.
- data_valid  output  1  one-cycle pulse, sum_output valid.
- sat_flag  output  1  high with data_valid when clamping occurred.

Behaviour:
- Reset (rst=0 at a clock edge):
  - clears all pipeline data registers, valid/flag shift bits and the accumulator.
  - sum_output=0, data_valid=0, sat_flag=0 on the following cycle.
  - In-flight beats are discarded. A reset mid-group drops the partial group; the next result requires a new acc_first.
- Tree stages (L_TREE registered stages):
  - Stage k adds adjacent pairs, sign-extended by one bit per stage.
  - An odd leftover operand is registered unchanged (sign-extended) to the next stage.
  - Final tree sum is TREE_W bits and exact; no overflow is possible.
- Sideband: start_adder, acc_first, acc_last and bias travel in a shift register aligned with the tree data.
- Accumulate stage (1 registered stage), acting only on valid beats:
  - acc_first=1: acc = sext(tree_sum) + bias.
  - acc_first=0: acc = acc + sext(tree_sum).
  - Arithmetic is ACC_W two's complement and wraps on overflow; sizing ACC_BITS is the integrator's job.
  - acc_first=1 and acc_last=1 together form a single-beat group.
  - A beat with acc_first=0 while no group is open still adds into acc. The result is don't-care but must not hang the block.
  - Bubbles (start_adder=0) leave acc unchanged.
- Output stage (1 registered stage), when the accumulate stage holds a valid beat with acc_last=1:
  - sum_output = clamp(acc, -2^(OUT_W-1), 2^(OUT_W-1)-1).
  - sat_flag=1 iff clamped; data_valid=1 for exactly one cycle.
  - Otherwise data_valid=0 and sat_flag=0, and sum_output holds its last value.
  - If OUT_W >= ACC_W, the clamp never triggers.
- Latency: L_TREE+2 cycles from the start_adder sampling edge of the last beat to data_valid high. The default is 7.
- Throughput: back-to-back beats and back-to-back groups (acc_last followed by acc_first the next cycle) are supported with no bubbles.
- No backpressure; the consumer must accept every data_valid pulse.

Test Plan:
- Defaults, all 27 operands 14'b0000011_0100000 (416), first=last=1, bias=0 -> data_valid pulses 7 cycles after sampling, sum_output=11232, sat_flag=0.
- All operands -2, single-beat group, bias=0 -> sum_output=-54 (21-bit two's complement 0x1FFFCA).
- Three-beat group (first, middle, last) of all-416 operands, bias=100 -> exactly one data_valid, after the last beat, with sum_output=33796; no pulse for beats 1-2.
- OUT_W=16, all operands 8191, single-beat group -> raw 221157 clamps to 32767, sat_flag=1. Repeat with -8192 -> -32768, sat_flag=1.
- 10 consecutive single-beat groups with all operands set to k=1..10 -> 10 consecutive data_valid cycles giving 27*k in order, starting at cycle 7.
- Assert rst=0 for one cycle 3 cycles into a two-beat group -> data_valid stays 0 for that group. A new single-beat group of all-1 operands then yields 27 after 7 cycles.
